soc_bus_arbiter: RTL and testbench

SOC_BUS_ARBITER -- requirements
Module: soc_bus_arbiter

---
 rtl/soc_bus_arbiter.sv | 171 +++++++++++++++++
 tb/tb_soc_bus_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_bus_arbiter.sv
// Round-robin arbiter: NUM_MASTERS requesters share one memory slave, one
// transaction at a time, with an optional per-transaction response timeout.
//   state | meaning
//   IDLE  | waiting for any request; arbitrates and captures the winner
//   BUSY  | request presented to the slave; counting towards timeout
//   RESP  | one-cycle completion pulse to the granted master
module soc_bus_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int MEM_DEPTH   = 64,
    parameter int DATA_WIDTH  = 32,
    parameter int TIMEOUT     = 16,
    localparam int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
    input  logic                              clk_i,
    input  logic                              rst_n_i,
    input  logic [NUM_MASTERS-1:0]            m_req_valid_i,
    input  logic [NUM_MASTERS-1:0]            m_we_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata_i,
    output logic [DATA_WIDTH-1:0]             m_rdata_o,
    output logic [NUM_MASTERS-1:0]            m_data_valid_o,
    output logic [NUM_MASTERS-1:0]            m_error_o,
    output logic                              s_req_valid_o,
    output logic                              s_we_o,
    output logic [ADDR_WIDTH-1:0]             s_addr_o,
    output logic [DATA_WIDTH-1:0]             s_wdata_o,
    input  logic [DATA_WIDTH-1:0]             s_rdata_i,
    input  logic                              s_data_valid_i
);
    localparam int GW    = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [GW-1:0]    GRANT_RST = GW'(NUM_MASTERS - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    state_e                state_q, state_d;
    logic [GW-1:0]         grant_q, grant_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  drop_q, drop_d;

    logic                  hi_found;
    logic [GW-1:0]         hi_idx, lo_idx, winner;
    logic                  sel_we, grant_req;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    // Lowest requester above the last grant wins; otherwise wrap to the lowest overall.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (m_req_valid_i[i]) begin
                if (i > int'(grant_q)) begin
                    hi_found = 1'b1;
                    hi_idx   = GW'(i);
                end else begin
                    lo_idx = GW'(i);
                end
            end
        end
        winner = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        grant_req = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (GW'(i) == winner) begin
                sel_we    = m_we_i[i];
                sel_addr  = m_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = m_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
            if (GW'(i) == grant_q) begin
                grant_req = m_req_valid_i[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        drop_d  = drop_q;
        case (state_q)
            IDLE: begin
                if (|m_req_valid_i) begin
                    state_d = BUSY;
                    grant_d = winner;
                    we_d    = sel_we;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    cnt_d   = '0;
                    drop_d  = 1'b0;
                end
            end
            BUSY: begin
                // A master that lets go mid-transaction forfeits its completion pulse.
                drop_d = drop_q | ~grant_req;
                if (s_data_valid_i) begin
                    state_d = RESP;
                    rdata_d = we_q ? '0 : s_rdata_i;
                    err_d   = 1'b0;
                end else if (TIMEOUT > 0 && cnt_q == CNT_LAST) begin
                    state_d = RESP;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end else if (TIMEOUT > 0) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            grant_q <= GRANT_RST;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        m_data_valid_o = '0;
        m_error_o      = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (state_q == RESP && !drop_q && GW'(i) == grant_q) begin
                m_data_valid_o[i] = 1'b1;
                m_error_o[i]      = err_q;
            end
        end
    end

    assign m_rdata_o     = (state_q == RESP) ? rdata_q : '0;
    assign s_req_valid_o = (state_q == BUSY);
    assign s_we_o        = we_q;
    assign s_addr_o      = addr_q;
    assign s_wdata_o     = wdata_q;

endmodule

// File: tb/tb_soc_bus_arbiter.sv
// Bench for soc_bus_arbiter: TB-side masters and memory slave, a round-robin
// reference model feeding a response scoreboard, and an independent monitor.
module tb_soc_bus_arbiter;
    localparam int N     = 2;
    localparam int DEPTH = 64;
    localparam int DW    = 32;
    localparam int TO    = 4;
    localparam int AW    = $clog2(DEPTH);

    typedef struct {
        int            m;
        logic [DW-1:0] rdata;
        logic          err;
        int            cyc;
    } exp_t;

    logic clk_i = 1'b0;
    logic rst_n_i;
    always #5 clk_i = ~clk_i;

    logic [N-1:0]    t_req, t_we;
    logic [AW-1:0]   t_addr [N];
    logic [DW-1:0]   t_wdata [N];
    logic [N*AW-1:0] m_addr_p;
    logic [N*DW-1:0] m_wdata_p;
    logic [DW-1:0]   m_rdata_o;
    logic [N-1:0]    m_data_valid_o, m_error_o;
    logic            s_req_valid_o, s_we_o;
    logic [AW-1:0]   s_addr_o;
    logic [DW-1:0]   s_wdata_o;
    logic [DW-1:0]   s_rdata;
    logic            s_dv;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            m_addr_p[i*AW +: AW]  = t_addr[i];
            m_wdata_p[i*DW +: DW] = t_wdata[i];
        end
    end

    soc_bus_arbiter #(.NUM_MASTERS(N), .MEM_DEPTH(DEPTH), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .m_req_valid_i(t_req), .m_we_i(t_we), .m_addr_i(m_addr_p), .m_wdata_i(m_wdata_p),
        .m_rdata_o(m_rdata_o), .m_data_valid_o(m_data_valid_o), .m_error_o(m_error_o),
        .s_req_valid_o(s_req_valid_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
        .s_rdata_i(s_rdata), .s_data_valid_i(s_dv)
    );

    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    exp_t          sb[$];
    logic [DW-1:0] mem [DEPTH];

    int            last_g, busy_k, cur_g, cur_k, exp_len, force_k, max_gap;
    logic          prev_srv, auto_en, drop_next, dropped_cur;
    logic [N-1:0]  dv_seen;
    int            gap [N];
    logic [AW-1:0] cap_addr;
    logic          cap_we;
    logic [DW-1:0] cap_wdata;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference arbitration: first requester found walking forward from last grant.
    function automatic int rr(int last, logic [N-1:0] r);
        for (int off = 1; off <= N; off++)
            for (int i = 0; i < N; i++)
                if (i == (last + off) % N && r[i]) return i;
        return -1;
    endfunction

    exp_t          mon_e;
    logic [N-1:0]  mon_oh;
    always @(negedge clk_i) begin
        if (rst_n_i === 1'b1 && m_data_valid_o != '0) begin
            if (sb.size() == 0) begin
                chk("unexpected_data_valid", 64'(m_data_valid_o), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                for (int i = 0; i < N; i++) mon_oh[i] = (i == mon_e.m);
                chk("resp_onehot", 64'(m_data_valid_o), 64'(mon_oh));
                chk("resp_rdata", 64'(m_rdata_o), 64'(mon_e.rdata));
                chk("resp_error", 64'(m_error_o), mon_e.err ? 64'(mon_oh) : 64'd0);
                chk("resp_cycle", 64'(cyc), 64'(mon_e.cyc));
            end
        end
    end

    task automatic step();
        logic srv;
        exp_t e;
        @(posedge clk_i);
        #1;
        cyc++;
        if (!rst_n_i) begin
            s_dv     = 1'b0;
            prev_srv = 1'b0;
            return;
        end
        srv = s_req_valid_o;
        if (srv && !prev_srv) begin
            cur_g = rr(last_g, t_req);
            chk("grant_has_requester", 64'(cur_g >= 0), 64'd1);
            if (cur_g < 0) cur_g = 0;
            last_g = cur_g;
            for (int i = 0; i < N; i++) begin
                if (i == cur_g) begin
                    cap_addr  = t_addr[i];
                    cap_we    = t_we[i];
                    cap_wdata = t_wdata[i];
                end
            end
            cur_k       = (force_k > 0) ? force_k : int'($urandom_range(1, TO + 1));
            exp_len     = (cur_k <= TO) ? cur_k : TO;
            dropped_cur = drop_next;
            drop_next   = 1'b0;
            busy_k      = 0;
            if (!dropped_cur) begin
                e.m     = cur_g;
                e.err   = (cur_k > TO);
                e.rdata = (cur_k > TO || cap_we) ? '0 : mem[cap_addr];
                e.cyc   = cyc + exp_len;
                if (sb.size() != 0) chk("missing_response", 64'(sb.size()), 64'd0);
                sb.push_back(e);
            end
        end
        if (srv) begin
            busy_k++;
            chk("s_addr", 64'(s_addr_o), 64'(cap_addr));
            chk("s_we", 64'(s_we_o), 64'(cap_we));
            if (cap_we) chk("s_wdata", 64'(s_wdata_o), 64'(cap_wdata));
        end else if (prev_srv) begin
            chk("busy_cycles", 64'(busy_k), 64'(exp_len));
        end
        if (srv && busy_k == cur_k) begin
            s_dv = 1'b1;
            if (cap_we) begin
                mem[cap_addr] = cap_wdata;
                s_rdata       = $urandom;
            end else begin
                s_rdata = mem[cap_addr];
            end
        end else begin
            s_dv    = !srv && ($urandom_range(0, 7) == 0);
            s_rdata = $urandom;
        end
        prev_srv = srv;
        for (int i = 0; i < N; i++) begin
            if (dv_seen[i]) begin
                t_req[i]   = 1'b0;
                dv_seen[i] = 1'b0;
                gap[i]     = int'($urandom_range(0, max_gap));
            end else if (m_data_valid_o[i]) begin
                dv_seen[i] = 1'b1;
            end else if (srv && busy_k == 1 && dropped_cur && cur_g == i) begin
                t_req[i]  = 1'b0;
                t_addr[i] = AW'($urandom);
                gap[i]    = 0;
            end else if (!t_req[i] && auto_en) begin
                if (gap[i] > 0) begin
                    gap[i]--;
                end else begin
                    t_req[i]   = 1'b1;
                    t_we[i]    = 1'($urandom_range(0, 1));
                    t_addr[i]  = AW'($urandom);
                    t_wdata[i] = $urandom;
                end
            end
        end
    endtask

    task automatic issue(int m, logic we, logic [AW-1:0] a, logic [DW-1:0] d);
        for (int i = 0; i < N; i++) begin
            if (i == m) begin
                t_req[i]   = 1'b1;
                t_we[i]    = we;
                t_addr[i]  = a;
                t_wdata[i] = d;
            end
        end
    endtask

    task automatic wait_idle(int limit);
        int n = 0;
        while (n < limit && (t_req != '0 || dv_seen != '0 || sb.size() != 0 || prev_srv)) begin
            step();
            n++;
        end
        if (t_req != '0 || dv_seen != '0 || sb.size() != 0 || prev_srv) begin
            total++;
            bad++;
            $display("FAIL wait_idle: bus still busy after %0d cycles, required idle", limit);
        end
    endtask

    task automatic wait_srv(int limit);
        for (int n = 0; n < limit; n++) begin
            step();
            if (s_req_valid_o) break;
        end
        if (!s_req_valid_o) begin
            total++;
            bad++;
            $display("FAIL wait_srv: s_req_valid low after %0d cycles, required high", limit);
        end
    endtask

    initial begin
        rst_n_i = 1'b1;
        t_req = '0; t_we = '0;
        for (int i = 0; i < N; i++) begin
            t_addr[i] = '0; t_wdata[i] = '0; gap[i] = 0;
        end
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        s_dv = 1'b0; s_rdata = '0;
        last_g = N - 1; busy_k = 0; cur_g = 0; cur_k = 1; exp_len = 1;
        force_k = 0; max_gap = 3; prev_srv = 1'b0; auto_en = 1'b0;
        drop_next = 1'b0; dropped_cur = 1'b0; dv_seen = '0;
        cap_addr = '0; cap_we = 1'b0; cap_wdata = '0;
        #1 rst_n_i = 1'b0;
        #10;
        chk("rst_s_req_valid", 64'(s_req_valid_o), 64'd0);
        chk("rst_s_we", 64'(s_we_o), 64'd0);
        chk("rst_s_addr", 64'(s_addr_o), 64'd0);
        chk("rst_s_wdata", 64'(s_wdata_o), 64'd0);
        chk("rst_m_rdata", 64'(m_rdata_o), 64'd0);
        chk("rst_m_data_valid", 64'(m_data_valid_o), 64'd0);
        chk("rst_m_error", 64'(m_error_o), 64'd0);
        @(posedge clk_i);
        #1 rst_n_i = 1'b1;

        // Single read, memory answers two cycles after the request appears.
        mem[5] = 32'h1234_5678;
        force_k = 3;
        issue(0, 1'b0, 6'd5, '0);
        wait_idle(50);

        // Write then read back at the top address.
        force_k = 2;
        issue(1, 1'b1, 6'(DEPTH - 1), 32'hA5A5_A5A5);
        wait_idle(50);
        force_k = 1;
        issue(1, 1'b0, 6'(DEPTH - 1), '0);
        wait_idle(50);

        // Slave never answers, then answers exactly on the terminal count.
        force_k = TO + 1;
        issue(0, 1'b0, 6'd7, '0);
        wait_idle(50);
        force_k = TO;
        issue(1, 1'b0, 6'd9, '0);
        wait_idle(50);

        // Continuous contention from both masters.
        force_k = 0; max_gap = 0; auto_en = 1'b1;
        repeat (80) step();
        auto_en = 1'b0;
        wait_idle(50);

        // Randomised traffic.
        max_gap = 3; auto_en = 1'b1;
        repeat (3000) step();
        auto_en = 1'b0;
        wait_idle(50);

        // Granted master drops its request mid-transaction; next grant still rotates.
        force_k = 3; drop_next = 1'b1;
        issue(0, 1'b0, 6'd11, '0);
        wait_idle(50);
        force_k = 0;
        issue(0, 1'b0, 6'd12, '0);
        issue(1, 1'b0, 6'd13, '0);
        wait_idle(50);

        // Reset while the slave request is active.
        force_k = TO + 1;
        issue(1, 1'b0, 6'd3, '0);
        wait_srv(20);
        rst_n_i = 1'b0;
        #1;
        chk("midrst_s_req_valid", 64'(s_req_valid_o), 64'd0);
        chk("midrst_m_data_valid", 64'(m_data_valid_o), 64'd0);
        sb.delete();
        last_g = N - 1; busy_k = 0; prev_srv = 1'b0; t_req = '0; dv_seen = '0;
        repeat (3) step();
        rst_n_i = 1'b1;
        force_k = 2;
        issue(0, 1'b0, 6'd20, '0);
        issue(1, 1'b0, 6'd40, '0);
        wait_srv(20);
        chk("post_reset_first_grant_addr", 64'(s_addr_o), 64'd20);
        wait_idle(50);

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
